// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The slave modport is the adder's view; the master modport drives operands and consumes results.
interface adder_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
);
  localparam int CW = $clog2(STAGES + 1);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       f_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] y_o;
  logic             carry_o;
  logic             ovf_o;
  logic             zero_o;
  logic             err_o;
  logic [CW-1:0]    count_o;

  modport slave (
    input  in_valid_i, f_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, y_o, carry_o, ovf_o, zero_o, err_o, count_o
  );

  modport master (
    output in_valid_i, f_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, y_o, carry_o, ovf_o, zero_o, err_o, count_o
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined multi-mode adder (unsigned / ones'-complement / two's-complement) with
// optional saturation and a bubble-collapsing valid/ready pipeline of STAGES registers.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter bit SAT    = 1'b0
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);
  localparam int CW = $clog2(STAGES + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sumRaw;
  logic [WIDTH-1:0] yWrap;
  logic [WIDTH-1:0] yCalc;
  logic             carryCalc;
  logic             ovfCalc;
  logic             zeroCalc;
  logic             errCalc;
  logic             aMsb;
  logic             bMsb;

  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0][WIDTH-1:0] y_q;
  logic [STAGES-1:0]            carry_q;
  logic [STAGES-1:0]            ovf_q;
  logic [STAGES-1:0]            zero_q;
  logic [STAGES-1:0]            err_q;
  logic [STAGES-1:0]            adv;
  logic                         accept;
  logic [CW-1:0]                countSum;

  always_comb begin
    sumRaw    = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    aMsb      = bus.a_i[WIDTH-1];
    bMsb      = bus.b_i[WIDTH-1];
    yWrap     = sumRaw[WIDTH-1:0];
    carryCalc = sumRaw[WIDTH];
    ovfCalc   = 1'b0;
    errCalc   = 1'b0;
    case (bus.f_i)
      2'b00: ovfCalc = sumRaw[WIDTH];
      2'b01: begin
        // End-around carry folds the carry-out back into the LSB.
        yWrap   = sumRaw[WIDTH-1:0] + WIDTH'(sumRaw[WIDTH]);
        ovfCalc = (aMsb == bMsb) && (yWrap[WIDTH-1] != aMsb);
      end
      2'b10: ovfCalc = (aMsb == bMsb) && (yWrap[WIDTH-1] != aMsb);
      default: begin
        yWrap     = '0;
        carryCalc = 1'b0;
        errCalc   = 1'b1;
      end
    endcase
    yCalc = yWrap;
    if (SAT && ovfCalc) begin
      if (bus.f_i == 2'b00) yCalc = ALL_ONES;
      else                  yCalc = aMsb ? MIN_NEG : MAX_POS;
    end
    zeroCalc = (yCalc == '0) || ((bus.f_i == 2'b01) && (yCalc == ALL_ONES));
  end

  // A stage may move when it is empty or everything downstream of it moves.
  always_comb begin
    logic down;
    adv  = '0;
    down = bus.out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      down   = !valid_q[k] || down;
      adv[k] = down;
    end
  end

  assign accept         = bus.in_valid_i && adv[0];
  assign bus.in_ready_o = adv[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      y_q     <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
      zero_q  <= '0;
      err_q   <= '0;
    end else begin
      if (adv[0]) begin
        valid_q[0] <= accept;
        if (accept) begin
          y_q[0]     <= yCalc;
          carry_q[0] <= carryCalc;
          ovf_q[0]   <= ovfCalc;
          zero_q[0]  <= zeroCalc;
          err_q[0]   <= errCalc;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            y_q[k]     <= y_q[k-1];
            carry_q[k] <= carry_q[k-1];
            ovf_q[k]   <= ovf_q[k-1];
            zero_q[k]  <= zero_q[k-1];
            err_q[k]   <= err_q[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && bus.f_i == 2'b11)
      $warning("adder_pipe: reserved mode 11 requested, result forced to zero");
  end

  always_comb begin
    countSum = '0;
    for (int k = 0; k < STAGES; k++) countSum = countSum + CW'(valid_q[k]);
  end

  // Result and flags are masked so an empty output slot always reads as zero.
  assign bus.out_valid_o = valid_q[STAGES-1];
  assign bus.y_o         = valid_q[STAGES-1] ? y_q[STAGES-1] : '0;
  assign bus.carry_o     = valid_q[STAGES-1] && carry_q[STAGES-1];
  assign bus.ovf_o       = valid_q[STAGES-1] && ovf_q[STAGES-1];
  assign bus.zero_o      = valid_q[STAGES-1] && zero_q[STAGES-1];
  assign bus.err_o       = valid_q[STAGES-1] && err_q[STAGES-1];
  assign bus.count_o     = countSum;
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (WIDTH=4, STAGES=3): table-driven mode vectors on a wrapping and a
// saturating instance, scoreboard queues per instance, plus backpressure/bubble/reset sequences.
module tb_adder_pipe;
  localparam int W  = 4;
  localparam int S  = 3;
  localparam int NV = 16;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         o;
    logic         z;
    logic         e;
  } res_t;

  typedef struct packed {
    logic         sat;
    logic [1:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  res_t q0[$];
  res_t q1[$];
  res_t cur0;
  res_t cur1;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(W), .STAGES(S)) bus0 ();
  adder_pipe_if #(.WIDTH(W), .STAGES(S)) bus1 ();

  adder_pipe #(.WIDTH(W), .STAGES(S), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  adder_pipe #(.WIDTH(W), .STAGES(S), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic res_t mkRes(input logic [W-1:0] y, input logic c, o, z, e);
    res_t r;
    r.y = y; r.c = c; r.o = o; r.z = z; r.e = e;
    return r;
  endfunction

  function automatic vec_t mkVec(input logic sat, input logic [1:0] f,
                                 input logic [W-1:0] a, b, input res_t exp);
    vec_t v;
    v.sat = sat; v.f = f; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  // Reference for plain unsigned wrapping adds used by the sequence tests.
  function automatic res_t modelU(input logic [W-1:0] a, b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return mkRes(s[W-1:0], s[W], s[W], s[W-1:0] == '0, 1'b0);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input res_t got, input res_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got y=%h c=%b o=%b z=%b e=%b, expected y=%h c=%b o=%b z=%b e=%b",
               name, got.y, got.c, got.o, got.z, got.e, exp.y, exp.c, exp.o, exp.z, exp.e);
    end
  endtask

  // Scoreboards: pop on transfer first, then push on acceptance, both judged just before the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.out_valid_o && bus0.out_ready_i) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL sat0 stray beat: got y=%h, expected no beat", bus0.y_o);
        end else begin
          checkOutput("sat0 beat", {bus0.y_o, bus0.carry_o, bus0.ovf_o, bus0.zero_o, bus0.err_o},
                      q0.pop_front());
        end
      end
      if (bus0.in_valid_i && bus0.in_ready_o) q0.push_back(cur0);
      if (bus1.out_valid_o && bus1.out_ready_i) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL sat1 stray beat: got y=%h, expected no beat", bus1.y_o);
        end else begin
          checkOutput("sat1 beat", {bus1.y_o, bus1.carry_o, bus1.ovf_o, bus1.zero_o, bus1.err_o},
                      q1.pop_front());
        end
      end
      if (bus1.in_valid_i && bus1.in_ready_o) q1.push_back(cur1);
    end
  end

  task automatic idle();
    bus0.in_valid_i = 1'b0;
    bus1.in_valid_i = 1'b0;
  endtask

  task automatic driveVec(input vec_t v);
    if (!v.sat) begin
      bus1.in_valid_i = 1'b0;
      bus0.in_valid_i = 1'b1;
      bus0.f_i = v.f; bus0.a_i = v.a; bus0.b_i = v.b;
      cur0 = v.exp;
    end else begin
      bus0.in_valid_i = 1'b0;
      bus1.in_valid_i = 1'b1;
      bus1.f_i = v.f; bus1.a_i = v.a; bus1.b_i = v.b;
      cur1 = v.exp;
    end
  endtask

  // Offers one beat and returns 1ns after the edge that accepted it; in_valid stays high.
  task automatic applyStimulus(input vec_t v);
    logic acc;
    acc = 1'b0;
    driveVec(v);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = v.sat ? bus1.in_ready_o : bus0.in_ready_o;
      @(posedge clk); #1;
    end
    checkVal("beat accepted", 32'(acc), 32'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("drain pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    int accCount;
    int nextBeat;

    vecs[0]  = mkVec(1'b0, 2'b00, 4'h9, 4'h8, mkRes(4'h1, 1, 1, 0, 0));
    vecs[1]  = mkVec(1'b0, 2'b10, 4'h7, 4'h1, mkRes(4'h8, 0, 1, 0, 0));
    vecs[2]  = mkVec(1'b0, 2'b01, 4'hE, 4'h3, mkRes(4'h2, 1, 0, 0, 0));
    vecs[3]  = mkVec(1'b0, 2'b01, 4'h7, 4'h8, mkRes(4'hF, 0, 0, 1, 0));
    vecs[4]  = mkVec(1'b0, 2'b11, 4'h5, 4'h6, mkRes(4'h0, 0, 0, 1, 1));
    vecs[5]  = mkVec(1'b0, 2'b00, 4'h3, 4'h4, mkRes(4'h7, 0, 0, 0, 0));
    vecs[6]  = mkVec(1'b0, 2'b10, 4'hF, 4'h1, mkRes(4'h0, 1, 0, 1, 0));
    vecs[7]  = mkVec(1'b0, 2'b01, 4'hF, 4'h1, mkRes(4'h1, 1, 0, 0, 0));
    vecs[8]  = mkVec(1'b0, 2'b00, 4'h0, 4'h0, mkRes(4'h0, 0, 0, 1, 0));
    vecs[9]  = mkVec(1'b1, 2'b00, 4'h9, 4'h8, mkRes(4'hF, 1, 1, 0, 0));
    vecs[10] = mkVec(1'b1, 2'b10, 4'h7, 4'h1, mkRes(4'h7, 0, 1, 0, 0));
    vecs[11] = mkVec(1'b1, 2'b10, 4'h8, 4'hF, mkRes(4'h8, 1, 1, 0, 0));
    vecs[12] = mkVec(1'b1, 2'b01, 4'h8, 4'h8, mkRes(4'h8, 1, 1, 0, 0));
    vecs[13] = mkVec(1'b1, 2'b01, 4'h4, 4'h4, mkRes(4'h7, 0, 1, 0, 0));
    vecs[14] = mkVec(1'b1, 2'b00, 4'h2, 4'h3, mkRes(4'h5, 0, 0, 0, 0));
    vecs[15] = mkVec(1'b1, 2'b11, 4'h6, 4'h6, mkRes(4'h0, 0, 0, 1, 1));

    rst = 1'b1;
    bus0.out_ready_i = 1'b1;
    bus1.out_ready_i = 1'b1;
    bus1.in_valid_i = 1'b0;
    bus1.f_i = 2'b00; bus1.a_i = '0; bus1.b_i = '0;
    cur1 = '0;
    driveVec(mkVec(1'b0, 2'b00, 4'h3, 4'h4, modelU(4'h3, 4'h4)));

    // Reset held for two cycles with a beat offered.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkVal("reset out_valid", 32'(bus0.out_valid_o), 32'd0);
      checkVal("reset count", 32'(bus0.count_o), 32'd0);
      checkVal("reset in_ready", 32'(bus0.in_ready_o), 32'd1);
      checkVal("reset y", 32'(bus0.y_o), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: accepted at edge t, visible after edge t+2.
    @(negedge clk);
    checkVal("first in_ready", 32'(bus0.in_ready_o), 32'd1);
    @(posedge clk); #1;
    idle();
    checkVal("latency after t", 32'(bus0.out_valid_o), 32'd0);
    @(posedge clk); #1;
    checkVal("latency after t+1", 32'(bus0.out_valid_o), 32'd0);
    @(posedge clk); #1;
    checkVal("latency after t+2", 32'(bus0.out_valid_o), 32'd1);
    waitDrain();

    $display("[TB] mode and saturation vectors");
    for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);
    idle();
    waitDrain();

    $display("[TB] backpressure");
    bus0.out_ready_i = 1'b0;
    accCount = 0;
    nextBeat = 1;
    for (int c = 0; c < 5; c++) begin
      driveVec(mkVec(1'b0, 2'b00, W'(nextBeat), W'(nextBeat),
                     modelU(W'(nextBeat), W'(nextBeat))));
      @(negedge clk);
      if (bus0.in_ready_o) begin
        accCount++;
        nextBeat++;
      end
      @(posedge clk); #1;
    end
    checkVal("bp accepted", 32'(accCount), 32'd3);
    checkVal("bp in_ready", 32'(bus0.in_ready_o), 32'd0);
    checkVal("bp count", 32'(bus0.count_o), 32'd3);
    bus0.out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkVal("stream out_valid", 32'(bus0.out_valid_o), 32'd1);
      if (c < 2) checkVal("stream in_ready", 32'(bus0.in_ready_o), 32'd1);
      if (c == 0) checkVal("full pipe count", 32'(bus0.count_o), 32'd3);
      @(posedge clk); #1;
      if (c == 0) driveVec(mkVec(1'b0, 2'b00, 4'h5, 4'h5, modelU(4'h5, 4'h5)));
      if (c == 1) idle();
    end
    waitDrain();

    $display("[TB] bubble collapse");
    bus0.out_ready_i = 1'b0;
    applyStimulus(mkVec(1'b0, 2'b00, 4'h1, 4'h2, modelU(4'h1, 4'h2)));
    idle();
    @(posedge clk); #1;
    applyStimulus(mkVec(1'b0, 2'b00, 4'h3, 4'h4, modelU(4'h3, 4'h4)));
    idle();
    repeat (2) begin @(posedge clk); #1; end
    checkVal("bubble count 2", 32'(bus0.count_o), 32'd2);
    applyStimulus(mkVec(1'b0, 2'b00, 4'h5, 4'h6, modelU(4'h5, 4'h6)));
    idle();
    checkVal("bubble count 3", 32'(bus0.count_o), 32'd3);
    checkVal("bubble in_ready", 32'(bus0.in_ready_o), 32'd0);
    checkVal("bubble held y", 32'(bus0.y_o), 32'h3);
    bus0.out_ready_i = 1'b1;
    waitDrain();

    $display("[TB] reset mid-stream");
    bus0.out_ready_i = 1'b0;
    applyStimulus(mkVec(1'b0, 2'b00, 4'h1, 4'h1, modelU(4'h1, 4'h1)));
    applyStimulus(mkVec(1'b0, 2'b00, 4'h2, 4'h1, modelU(4'h2, 4'h1)));
    applyStimulus(mkVec(1'b0, 2'b00, 4'h3, 4'h1, modelU(4'h3, 4'h1)));
    idle();
    checkVal("inflight count", 32'(bus0.count_o), 32'd3);
    rst = 1'b1;
    #1;
    q0.delete();
    checkVal("midreset out_valid", 32'(bus0.out_valid_o), 32'd0);
    checkVal("midreset count", 32'(bus0.count_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.out_ready_i = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    checkVal("post reset count", 32'(bus0.count_o), 32'd0);
    checkVal("post reset out_valid", 32'(bus0.out_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
